// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, forwarding-select codes and the pipeline
// stage descriptor used by the hazard logic.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dst;
    logic [4:0] src_a;
    logic [4:0] src_b;
  } desc_t;

  // Youngest valid producer of src wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input desc_t mem, input desc_t wb,
                                         input logic [4:0] src);
    if (src == 5'd0)                                    return FWD_RF;
    else if (mem.valid && mem.regwrite && mem.dst == src) return FWD_MEM;
    else if (wb.valid && wb.regwrite && wb.dst == src)    return FWD_WB;
    else                                                return FWD_RF;
  endfunction
endpackage

// File: rtl/hz_decode.sv
// Decodes an instruction into a stage descriptor; unused sources read as $0
// so they can never match a producer.
module hz_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output desc_t       desc
);
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       unused_bits;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^instr[10:0];

  always_comb begin
    desc       = '0;
    desc.valid = 1'b1;
    case (op)
      OP_RTYPE: begin desc.src_a = rs; desc.src_b = rt; desc.dst = rd; desc.regwrite = 1'b1; end
      OP_ADDI:  begin desc.src_a = rs; desc.dst = rt; desc.regwrite = 1'b1; end
      OP_LW:    begin desc.src_a = rs; desc.dst = rt; desc.regwrite = 1'b1; desc.memread = 1'b1; end
      OP_SW,
      OP_BEQ:   begin desc.src_a = rs; desc.src_b = rt; end
      default:  ;
    endcase
    // A write to $0 is discarded, so it is not a producer.
    if (desc.dst == 5'd0) begin
      desc.regwrite = 1'b0;
      desc.memread  = 1'b0;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: EX operand forwarding, load-use stall,
// taken-branch flush and saturating event counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  desc_t id_d, ex_q, mem_q, wb_q;
  logic  load_use;
  logic  unused_fields;

  hz_decode u_dec (.instr(id_instr), .desc(id_d));

  assign unused_fields = ^{mem_q.memread, mem_q.src_a, mem_q.src_b,
                           wb_q.memread, wb_q.src_a, wb_q.src_b, id_d.valid,
                           id_d.regwrite, id_d.memread, id_d.dst};

  assign load_use = id_valid && ex_q.valid && ex_q.memread && ex_q.dst != 5'd0 &&
                    (ex_q.dst == id_d.src_a || ex_q.dst == id_d.src_b);

  // Flush takes priority: the dependent in ID is squashed anyway.
  assign flush      = branch_taken && !Reset;
  assign stall      = load_use && !branch_taken && !Reset;
  assign pc_write   = !stall;
  assign ifid_write = !stall;

  assign fwd_a = ex_q.valid ? fwd_sel(mem_q, wb_q, ex_q.src_a) : FWD_RF;
  assign fwd_b = ex_q.valid ? fwd_sel(mem_q, wb_q, ex_q.src_b) : FWD_RF;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (id_valid && !stall && !flush) ? id_d : '0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding cases, load-use, flush priority,
// reset abort and counter saturation.
module tb_hazard_ctrl;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             Reset;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic             branch_taken;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, flush, pc_write, ifid_write;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_instr(id_instr),
    .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .flush(flush), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] lw(input int rt, input int rs, input logic [15:0] imm);
    return {6'b100011, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick; @(posedge clk); #1; endtask

  task automatic issue(input logic [31:0] ins);
    id_valid = 1'b1; id_instr = ins; tick();
  endtask

  task automatic drain;
    id_valid = 1'b0; id_instr = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    Reset = 1'b1; branch_taken = 1'b1; id_valid = 1'b1; id_instr = lw(4, 0, 16'd4);
    tick(); tick();
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL reset_fwd a=%b b=%b want 00 00", fwd_a, fwd_b); end
    checks++; if (stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL reset_stall_flush stall=%b flush=%b want 0 0", stall, flush); end
    checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin failures++; $display("FAIL reset_wr pc=%b ifid=%b want 1 1", pc_write, ifid_write); end
    checks++; if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt s=%0d f=%0d want 0 0", stall_cnt, flush_cnt); end
    branch_taken = 1'b0; id_valid = 1'b0; id_instr = '0;
    Reset = 1'b0; tick();
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL bubble_fwd a=%b b=%b want 00 00", fwd_a, fwd_b); end
  endtask

  task automatic test_one_ahead;
    issue(rtype(1, 2, 3, 6'h20));
    issue(rtype(5, 1, 8, 6'h20));
    checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin failures++; $display("FAIL one_ahead a=%b b=%b want 10 00", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_two_ahead;
    issue(rtype(9, 10, 11, 6'h20));
    issue(rtype(12, 13, 14, 6'h20));
    issue(rtype(15, 16, 9, 6'h20));
    checks++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin failures++; $display("FAIL two_ahead a=%b b=%b want 00 01", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_arbitration;
    issue(rtype(1, 2, 4, 6'h20));
    issue(rtype(1, 2, 3, 6'h20));
    issue(rtype(6, 7, 1, 6'h20));
    checks++; if (fwd_b !== 2'b10) begin failures++; $display("FAIL arbitration b=%b want 10", fwd_b); end
    drain();
  endtask

  task automatic test_zero_reg;
    issue(rtype(0, 1, 2, 6'h20));
    issue(rtype(31, 0, 31, 6'h20));
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL zero_reg a=%b b=%b want 00 00", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_load_use;
    issue(lw(4, 0, 16'd4));
    id_instr = rtype(7, 4, 6, 6'h22); #1;
    checks++; if (stall !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0) begin failures++; $display("FAIL load_use_stall stall=%b pc=%b ifid=%b want 1 0 0", stall, pc_write, ifid_write); end
    tick();
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin failures++; $display("FAIL load_use_one_cycle stall=%b pc=%b want 0 1", stall, pc_write); end
    tick();
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin failures++; $display("FAIL load_use_fwd a=%b b=%b want 01 00", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 3'd1) begin failures++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
    drain();
  endtask

  task automatic test_branch_coincide;
    issue(lw(4, 0, 16'd4));
    id_instr = rtype(7, 4, 6, 6'h22); branch_taken = 1'b1; #1;
    checks++; if (flush !== 1'b1 || stall !== 1'b0 || pc_write !== 1'b1) begin failures++; $display("FAIL coincide flush=%b stall=%b pc=%b want 1 0 1", flush, stall, pc_write); end
    tick();
    branch_taken = 1'b0; #1;
    checks++; if (flush_cnt !== 3'd1 || stall_cnt !== 3'd1) begin failures++; $display("FAIL coincide_cnt f=%0d s=%0d want 1 1", flush_cnt, stall_cnt); end
    checks++; if (stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL coincide_after stall=%b flush=%b want 0 0", stall, flush); end
    // The flushed slot must be a bubble: nothing in MEM to forward from.
    issue(rtype(8, 4, 0, 6'h20));
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL coincide_bubble a=%b want 01", fwd_a); end
    drain();
  endtask

  task automatic test_reset_mid_stall;
    issue(lw(4, 0, 16'd4));
    id_instr = rtype(7, 4, 6, 6'h22); #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got %b want 1", stall); end
    Reset = 1'b1; #1;
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1 || ifid_write !== 1'b1 || stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin
      failures++; $display("FAIL mid_stall_reset stall=%b pc=%b ifid=%b s=%0d f=%0d want 0 1 1 0 0", stall, pc_write, ifid_write, stall_cnt, flush_cnt); end
    tick();
    Reset = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got %b want 0", stall); end
    tick();
    issue(rtype(8, 7, 0, 6'h20));
    checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL post_reset_no_bubble a=%b want 10", fwd_a); end
    drain();
  endtask

  task automatic test_saturation;
    Reset = 1'b1; tick(); Reset = 1'b0;
    branch_taken = 1'b1;
    repeat (10) tick();
    checks++; if (flush_cnt !== 3'd7) begin failures++; $display("FAIL flush_sat got %0d want 7", flush_cnt); end
    branch_taken = 1'b0;
    for (int i = 0; i < 9; i++) begin
      issue(lw(4, 0, 16'd0));
      id_instr = rtype(7, 4, 6, 6'h22); tick();
      id_valid = 1'b0; tick();
    end
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL stall_sat got %0d want 7", stall_cnt); end
  endtask

  initial begin
    Reset = 1'b1; id_valid = 1'b0; id_instr = '0; branch_taken = 1'b0;
    test_reset();
    test_one_ahead();
    test_two_ahead();
    test_arbitration();
    test_zero_reg();
    test_load_use();
    test_branch_coincide();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating event counters.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-005 SHALL have port id_instr  input  32  instruction currently in ID.
REQ-006 SHALL have port branch_taken  input  1  EX resolved a taken beq this cycle.
REQ-007 SHALL have port fwd_a  output  2  EX operand-A source: 00 regfile, 10 MEM result, 01 WB result.
REQ-008 SHALL have port fwd_b  output  2  EX operand-B source, same encoding.
REQ-009 SHALL have port stall  output  1  load-use stall this cycle.
REQ-010 SHALL have port flush  output  1  squash IF/ID this cycle.
REQ-011 SHALL have port pc_write  output  1  PC update enable.
REQ-012 SHALL have port ifid_write  output  1  IF/ID register update enable.
REQ-013 SHALL have ports stall_cnt and flush_cnt  output  CNT_W  event counters.

Function
REQ-014 SHALL decode id_instr: R-type (op 000000): uses rs,rt, writes rd; addi (001000): uses rs, writes rt; lw (100011): uses rs, writes rt, memread; sw (101011) and beq (000100): use rs,rt, no write; any other opcode: no use, no write.
REQ-015 SHALL keep three registered stage descriptors, EX, MEM and WB, each {valid, regwrite, memread, dst[4:0], src_a[4:0], src_b[4:0]}.
REQ-016 SHALL treat a write to register 0 as no write when a descriptor is built.
REQ-017 SHALL, each cycle, shift WB<=MEM and MEM<=EX; EX <= decoded ID if id_valid and not stall and not flush, else a bubble (valid=0).
REQ-018 SHALL drive fwd_a=10 when MEM.valid, MEM.regwrite and MEM.dst==EX.src_a!=0; else 01 when the same holds for WB; else 00. The youngest producer wins.
REQ-019 SHALL compute fwd_b identically against EX.src_b.
REQ-020 SHALL drive fwd_a and fwd_b combinationally from registered descriptors only.
REQ-021 SHALL drive fwd_a=fwd_b=00 while EX is a bubble.
REQ-022 SHALL assert stall combinationally when EX.valid, EX.memread and EX.dst is nonzero and equals an ID-used source.
REQ-023 SHALL hold a stall for exactly one cycle, because the inserted bubble clears the condition.
REQ-024 SHALL drive flush=branch_taken.
REQ-025 SHALL let flush win when branch_taken and the stall condition coincide: stall=0, and a bubble enters EX.
REQ-026 SHALL drive pc_write = ifid_write = !stall. A flush does not block the PC update.
REQ-027 SHALL increment stall_cnt on each stall cycle and flush_cnt on each flush cycle.
REQ-028 SHALL saturate both counters at all-ones, with no wrap-around.
REQ-029 SHALL leave same-cycle WB-to-ID bypass (three-ahead) to the register file; it is out of scope here.

Reset
REQ-030 SHALL, while Reset is high, clear all descriptors to invalid and both counters to 0.
REQ-031 SHALL, while Reset is high, drive fwd_a=fwd_b=00, stall=0, flush=0 and pc_write=ifid_write=1.
REQ-032 SHALL let Reset asserted mid-stall or mid-flush abort the event immediately, with no residual bubble after release.

Structure
REQ-033 SHALL take opcode constants, forwarding-select codes and the descriptor field layout from the shared cpu_pkg.
REQ-034 SHALL implement instruction decode (REQ-014, REQ-016) as sub-module hz_decode, instantiated once for id_instr.

Verification
REQ-035 SHALL cover one-ahead: add $1,$2,$3 then add $5,$1,$8 -> fwd_a=10 when the second add is in EX.
REQ-036 SHALL cover two-ahead: add $9,$10,$11; add $12,$13,$14; add $15,$16,$9 -> fwd_b=01 for the third add in EX.
REQ-037 SHALL cover arbitration: add $1,$2,$4; add $1,$2,$3; add $6,$7,$1 -> fwd_b=10 (MEM, youngest), never 01.
REQ-038 SHALL cover the zero register: add $0,$1,$2 then add $31,$0,$31 -> fwd_a=00.
REQ-039 SHALL cover load-use: lw $4,4($0) then sub $7,$4,$6 -> stall=1 for one cycle with pc_write=0, then fwd_a=01, and stall_cnt=1.
REQ-040 SHALL cover branch and coincidence: branch_taken=1 while ID holds a load-use dependent -> flush=1, stall=0, flush_cnt=1; then Reset mid-stall -> all outputs at reset values next cycle.
